// File: rtl/tile_writeback.sv
// rtl/tile_writeback.sv - buffers 4x4 int8 tiles and writes them to tensor RAM as four 32-bit beats
module tile_writeback #(
  parameter int MAX_N      = 64,
  parameter int N_BITS     = $clog2(MAX_N),
  parameter int ADDR_BITS  = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [127:0]         in_data,
  input  logic [N_BITS-1:0]    in_row,
  input  logic [N_BITS-1:0]    in_col,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic [N_BITS-1:0]    chunks_per_row,
  input  logic                 layer_done,
  input  logic                 ram_ready,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [31:0]          wr_data,
  output logic                 idle,
  output logic                 writeback_done,
  output logic                 overflow
);

  localparam int PTR_BITS = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_BITS = PTR_BITS + 1;
  localparam int CALC_W   = ADDR_BITS + 2 * N_BITS + 2;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FLUSH} state_t;

  state_t state, state_next;

  logic [127:0]         mem_data [FIFO_DEPTH];
  logic [N_BITS-1:0]    mem_row  [FIFO_DEPTH];
  logic [N_BITS-1:0]    mem_col  [FIFO_DEPTH];
  logic [ADDR_BITS-1:0] mem_base [FIFO_DEPTH];
  logic [N_BITS-1:0]    mem_cpr  [FIFO_DEPTH];

  logic [PTR_BITS-1:0] wr_ptr, rd_ptr;
  logic [CNT_BITS-1:0] count, count_next;
  logic [1:0]          beat, beat_next;
  logic                pending, pending_next;
  logic                done_next;

  logic writing, accept, pop, push, full, drop, pending_eff;
  logic [CALC_W-1:0] row_c, col_c, addr_full;
  logic [127:0]      head_data;

  assign writing     = (state != S_IDLE);
  assign accept      = writing && ram_ready;
  assign pop         = accept && (beat == 2'd3);
  assign full        = (count == CNT_BITS'(FIFO_DEPTH));
  assign push        = in_valid && (!full || pop);
  assign drop        = in_valid && full && !pop;
  assign count_next  = count + CNT_BITS'(push) - CNT_BITS'(pop);
  assign pending_eff = pending || layer_done;

  // Beat address: chunk row/col are half the element coordinates; beat bit1 picks the lower chunk row, bit0 the right chunk.
  assign head_data = mem_data[rd_ptr];
  assign row_c     = CALC_W'(mem_row[rd_ptr] >> 1) + CALC_W'(beat[1]);
  assign col_c     = CALC_W'(mem_col[rd_ptr] >> 1) + CALC_W'(beat[0]);
  assign addr_full = CALC_W'(mem_base[rd_ptr]) + row_c * CALC_W'(mem_cpr[rd_ptr]) + col_c;

  always_comb begin
    wr_en   = writing;
    wr_addr = '0;
    wr_data = '0;
    if (writing) begin
      wr_addr = addr_full[ADDR_BITS-1:0];
      case (beat)
        2'd0:    wr_data = head_data[127:96];
        2'd1:    wr_data = head_data[95:64];
        2'd2:    wr_data = head_data[63:32];
        default: wr_data = head_data[31:0];
      endcase
    end
  end

  assign idle = (state == S_IDLE) && (count == '0) && !pending;

  always_comb begin
    state_next   = state;
    beat_next    = accept ? beat + 2'd1 : beat;
    done_next    = 1'b0;
    case (state)
      S_IDLE: begin
        // A layer_done sharing a cycle with a pushed tile must wait for that tile.
        if (count == '0 && !push && pending_eff) begin
          done_next = 1'b1;
        end
        if (count != '0) begin
          state_next = pending_eff ? S_FLUSH : S_WRITE;
        end
      end
      S_WRITE, S_FLUSH: begin
        if (pop && count_next == '0) begin
          state_next = S_IDLE;
          done_next  = pending_eff;
        end else if (pending_eff) begin
          state_next = S_FLUSH;
        end
      end
      default: state_next = S_IDLE;
    endcase
    pending_next = done_next ? 1'b0 : pending_eff;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      beat           <= 2'd0;
      pending        <= 1'b0;
      writeback_done <= 1'b0;
      overflow       <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
    end else begin
      state          <= state_next;
      beat           <= beat_next;
      pending        <= pending_next;
      writeback_done <= done_next;
      overflow       <= overflow || drop;
      count          <= count_next;
      if (push) wr_ptr <= wr_ptr + PTR_BITS'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= in_data;
      mem_row[wr_ptr]  <= in_row;
      mem_col[wr_ptr]  <= in_col;
      mem_base[wr_ptr] <= base_addr;
      mem_cpr[wr_ptr]  <= chunks_per_row;
    end
  end

endmodule

// File: tb/tb_tile_writeback.sv
// tb/tb_tile_writeback.sv - self-checking bench for tile_writeback against a tile-to-beat reference model
module tb_tile_writeback;
  localparam int N_BITS = 6;
  localparam int ADDR_BITS = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic [127:0] in_data = '0;
  logic [N_BITS-1:0] in_row = '0, in_col = '0, chunks_per_row = '0;
  logic [ADDR_BITS-1:0] base_addr = '0;
  logic layer_done = 1'b0;
  logic ram_ready = 1'b1;
  logic wr_en, idle, writeback_done, overflow;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [31:0] wr_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [15:0] got_addr[$];
  logic [31:0] got_data[$];
  int          got_cyc[$];
  int          done_cyc[$];
  bit          idle_at[int];
  logic [15:0] exp_addr[$];
  logic [31:0] exp_data[$];

  tile_writeback #(.MAX_N(64), .N_BITS(N_BITS), .ADDR_BITS(ADDR_BITS), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_row(in_row), .in_col(in_col), .base_addr(base_addr),
    .chunks_per_row(chunks_per_row), .layer_done(layer_done), .ram_ready(ram_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .idle(idle),
    .writeback_done(writeback_done), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every beat the RAM accepts (it takes effect on the following rising edge).
  always @(negedge clk) begin
    idle_at[cyc] = idle;
    if (!reset && wr_en && ram_ready) begin
      got_addr.push_back(wr_addr);
      got_data.push_back(wr_data);
      got_cyc.push_back(cyc);
    end
    if (writeback_done) done_cyc.push_back(cyc);
  end

  function automatic logic [15:0] model_addr(int base, int cpr, int row, int col, int c);
    int a;
    a = base + (row / 2 + c / 2) * cpr + col / 2 + c % 2;
    return a[15:0];
  endfunction

  task automatic clear_logs();
    got_addr.delete(); got_data.delete(); got_cyc.delete();
    exp_addr.delete(); exp_data.delete(); done_cyc.delete();
  endtask

  task automatic push_tile(input logic [127:0] d, input int row, input int col, input int base,
                           input int cpr, input bit expect_written, input bit with_done);
    in_data = d; in_row = N_BITS'(row); in_col = N_BITS'(col);
    base_addr = ADDR_BITS'(base); chunks_per_row = N_BITS'(cpr);
    in_valid = 1'b1; layer_done = with_done;
    if (expect_written) begin
      for (int c = 0; c < 4; c++) begin
        exp_addr.push_back(model_addr(base, cpr, row, col, c));
        exp_data.push_back(d[127 - 32 * c -: 32]);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; layer_done = 1'b0;
  endtask

  task automatic push_random(input bit expect_written, input bit with_done);
    logic [127:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    push_tile(d, $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 65535),
              $urandom_range(1, 63), expect_written, with_done);
  endtask

  task automatic wait_beats(input int n, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (got_addr.size() >= n) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
    checks++; if (wr_addr !== '0) begin failures++; $display("FAIL reset_wr_addr got=%h exp=0", wr_addr); end
    checks++; if (wr_data !== '0) begin failures++; $display("FAIL reset_wr_data got=%h exp=0", wr_data); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b exp=1", idle); end
    checks++; if (writeback_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", writeback_done); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_single();
    logic [15:0] k_addr[4];
    bit ok;
    k_addr = '{16'h113, 16'h114, 16'h11B, 16'h11C};
    clear_logs();
    push_tile(128'h00112233_44556677_8899AABB_CCDDEEFF, 4, 6, 'h100, 8, 1'b1, 1'b0);
    wait_beats(4, 40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout got=%0d exp=4 beats", got_addr.size()); end
    repeat (6) @(posedge clk); #1;
    checks++; if (got_addr.size() != 4) begin failures++; $display("FAIL single_count got=%0d exp=4", got_addr.size()); end
    for (int i = 0; i < 4 && i < got_addr.size(); i++) begin
      checks++; if (got_addr[i] !== k_addr[i]) begin failures++; $display("FAIL single_addr[%0d] got=%h exp=%h", i, got_addr[i], k_addr[i]); end
      checks++; if (got_data[i] !== exp_data[i]) begin failures++; $display("FAIL single_data[%0d] got=%h exp=%h", i, got_data[i], exp_data[i]); end
      if (i > 0) begin
        checks++; if (got_cyc[i] != got_cyc[i-1] + 1) begin failures++; $display("FAIL single_consecutive[%0d] got=%0d exp=%0d", i, got_cyc[i], got_cyc[i-1] + 1); end
      end
    end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL single_idle got=%b exp=1", idle); end
  endtask

  task automatic test_backpressure();
    logic [15:0] a;
    logic [31:0] d;
    bit ok;
    clear_logs();
    push_random(1'b1, 1'b0);
    wait_beats(1, 40, ok);
    ram_ready = 1'b0;
    a = wr_addr; d = wr_data;
    checks++; if (!ok || a !== exp_addr[1] || d !== exp_data[1]) begin
      failures++; $display("FAIL bp_beat1 got=%h/%h exp=%h/%h", a, d, exp_addr[1], exp_data[1]);
    end
    repeat (3) begin
      @(negedge clk);
      checks++; if (wr_en !== 1'b1 || wr_addr !== a || wr_data !== d) begin
        failures++; $display("FAIL bp_hold got=%b %h %h exp=1 %h %h", wr_en, wr_addr, wr_data, a, d);
      end
      @(posedge clk); #1;
    end
    ram_ready = 1'b1;
    wait_beats(4, 40, ok);
    repeat (6) @(posedge clk); #1;
    checks++; if (got_addr.size() != 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", got_addr.size()); end
    for (int i = 0; i < 4 && i < got_addr.size(); i++) begin
      checks++; if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        failures++; $display("FAIL bp_beat[%0d] got=%h/%h exp=%h/%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_logs();
    for (int t = 0; t < 8; t++) begin
      push_random(1'b1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
    end
    wait_beats(32, 100, ok);
    repeat (6) @(posedge clk); #1;
    checks++; if (got_addr.size() != 32) begin failures++; $display("FAIL b2b_count got=%0d exp=32", got_addr.size()); end
    for (int i = 0; i < 32 && i < got_addr.size(); i++) begin
      checks++; if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        failures++; $display("FAIL b2b_beat[%0d] got=%h/%h exp=%h/%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      end
    end
    if (got_cyc.size() == 32) begin
      checks++; if (got_cyc[31] - got_cyc[0] != 31) begin failures++; $display("FAIL b2b_contiguous got=%0d exp=31", got_cyc[31] - got_cyc[0]); end
    end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL b2b_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_overflow();
    bit ok;
    clear_logs();
    ram_ready = 1'b0;
    push_random(1'b1, 1'b0);
    push_random(1'b1, 1'b0);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_before got=%b exp=0", overflow); end
    push_random(1'b0, 1'b0);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_after got=%b exp=1", overflow); end
    repeat (2) @(posedge clk); #1;
    ram_ready = 1'b1;
    wait_beats(8, 60, ok);
    repeat (10) @(posedge clk); #1;
    checks++; if (got_addr.size() != 8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", got_addr.size()); end
    for (int i = 0; i < 8 && i < got_addr.size(); i++) begin
      checks++; if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        failures++; $display("FAIL ovf_beat[%0d] got=%h/%h exp=%h/%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      end
    end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_cleared got=%b exp=0", overflow); end
  endtask

  task automatic test_done();
    bit ok;
    clear_logs();
    push_random(1'b1, 1'b0);
    push_random(1'b1, 1'b1);
    wait_beats(8, 60, ok);
    repeat (6) @(posedge clk); #1;
    checks++; if (got_addr.size() != 8) begin failures++; $display("FAIL done_beats got=%0d exp=8", got_addr.size()); end
    for (int i = 0; i < 8 && i < got_addr.size(); i++) begin
      checks++; if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        failures++; $display("FAIL done_beat[%0d] got=%h/%h exp=%h/%h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      end
    end
    checks++; if (done_cyc.size() != 1) begin failures++; $display("FAIL done_pulses got=%0d exp=1", done_cyc.size()); end
    if (done_cyc.size() >= 1 && got_cyc.size() >= 8) begin
      checks++; if (done_cyc[0] != got_cyc[7] + 1) begin failures++; $display("FAIL done_timing got=%0d exp=%0d", done_cyc[0], got_cyc[7] + 1); end
      checks++; if (!idle_at.exists(done_cyc[0] + 1) || idle_at[done_cyc[0] + 1] !== 1'b1) begin
        failures++; $display("FAIL done_idle_after got=0 exp=1");
      end
    end
  endtask

  task automatic test_done_idle();
    int k;
    clear_logs();
    k = cyc;
    layer_done = 1'b1;
    @(posedge clk); #1;
    layer_done = 1'b0;
    repeat (4) @(posedge clk); #1;
    checks++; if (done_cyc.size() != 1) begin failures++; $display("FAIL idle_done_pulses got=%0d exp=1", done_cyc.size()); end
    if (done_cyc.size() >= 1) begin
      checks++; if (done_cyc[0] != k + 1) begin failures++; $display("FAIL idle_done_timing got=%0d exp=%0d", done_cyc[0], k + 1); end
    end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL idle_done_idle got=%b exp=1", idle); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_logs();
    push_random(1'b1, 1'b0);
    wait_beats(2, 40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rmid_timeout got=%0d exp=2 beats", got_addr.size()); end
    reset = 1'b1;
    in_data = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1; layer_done = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; layer_done = 1'b0;
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL rmid_wr_en got=%b exp=0", wr_en); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL rmid_idle got=%b exp=1", idle); end
    repeat (10) @(posedge clk); #1;
    checks++; if (got_addr.size() != 2) begin failures++; $display("FAIL rmid_beats got=%0d exp=2", got_addr.size()); end
    checks++; if (done_cyc.size() != 0) begin failures++; $display("FAIL rmid_done got=%0d exp=0", done_cyc.size()); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL rmid_idle_late got=%b exp=1", idle); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_done();
    test_done_idle();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
